// File: rtl/dense_mac_engine.sv
// Dense-layer MAC engine: streams LANES data/weight pairs per beat, accumulates
// BEATS beats plus a bias per neuron, and stores one saturated Q-format result per neuron.
module dense_mac_engine #(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 5,
   parameter int LANES   = 6,
   parameter int BEATS   = 4,
   parameter int NEURONS = 24,
   parameter int ACC_W   = 40
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      relu_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   data_in,
   input  logic [LANES*DATA_W-1:0]   weight_in,
   input  logic [DATA_W-1:0]         bias_in,
   output logic                      busy,
   output logic                      done,
   output logic                      out_valid,
   output logic                      ovf,
   output logic [NEURONS*DATA_W-1:0] data_out
);

   localparam int PW = 2*DATA_W;
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS-1);
   localparam logic [NW-1:0] NEUR_LAST = NW'(NEURONS-1);

   // Worst case |acc| <= (LANES*BEATS + 1) * 2^(2*DATA_W-2) when the shifted bias fits below one product.
   if (ACC_W < PW + $clog2(LANES*BEATS + 1) - 1 || FRAC_W >= DATA_W) begin : g_acc_w_check
      $error("dense_mac_engine: ACC_W too narrow for the worst-case accumulation");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state_q, state_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [NW-1:0] nidx_q, nidx_d;
   logic relu_q, relu_d;
   logic in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
   logic out_valid_q, out_valid_d, ovf_q, ovf_d;
   logic start_acc, accept;

   logic signed [PW-1:0] prod_p1_q [LANES];
   logic signed [PW-1:0] prod_p1_d [LANES];
   logic vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
   logic [NW-1:0] nidx_p1_q, nidx_p1_d;
   logic signed [DATA_W-1:0] bias_p1_q, bias_p1_d;

   logic signed [ACC_W-1:0] sum_p2_q, sum_p2_d;
   logic vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
   logic [NW-1:0] nidx_p2_q, nidx_p2_d;
   logic signed [DATA_W-1:0] bias_p2_q, bias_p2_d;

   logic signed [ACC_W-1:0] acc_p3_q, acc_p3_d;
   logic vld_p3_q, vld_p3_d, last_p3_q, last_p3_d;
   logic [NW-1:0] nidx_p3_q, nidx_p3_d;

   logic [DATA_W-1:0] slot_q [NEURONS];
   logic [DATA_W-1:0] slot_d [NEURONS];
   logic [DATA_W:0]   sat_res;

   // Returns {saturated, value} for acc >>> FRAC_W clipped to the signed DATA_W range.
   function automatic logic [DATA_W:0] shift_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> FRAC_W;
      if (sh[ACC_W-1:DATA_W-1] == '0 || sh[ACC_W-1:DATA_W-1] == '1)
         return {1'b0, sh[DATA_W-1:0]};
      else if (sh[ACC_W-1])
         return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   function automatic logic [DATA_W-1:0] relu_clamp(input logic [DATA_W-1:0] v, input logic en);
      return (en && v[DATA_W-1]) ? '0 : v;
   endfunction

   assign start_acc = start && (state_q == IDLE);
   assign accept    = in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      nidx_d  = nidx_q;
      relu_d  = relu_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            beat_d  = '0;
            nidx_d  = '0;
            relu_d  = relu_en;
         end
         RUN: if (accept) begin
            if (beat_q == BEAT_LAST) begin
               beat_d = '0;
               if (nidx_q == NEUR_LAST) begin
                  nidx_d  = '0;
                  state_d = DRAIN;
               end else begin
                  nidx_d = nidx_q + 1'b1;
               end
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         // Stage 3 retires its last entry on the same edge that enters DONE.
         DRAIN: if (!vld_p1_q && !vld_p2_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == RUN);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   // Stage 1: lane products
   always_comb begin
      logic signed [PW-1:0] d_ext, w_ext;
      for (int i = 0; i < LANES; i++) begin
         d_ext = {{DATA_W{data_in[(i+1)*DATA_W-1]}}, data_in[i*DATA_W +: DATA_W]};
         w_ext = {{DATA_W{weight_in[(i+1)*DATA_W-1]}}, weight_in[i*DATA_W +: DATA_W]};
         prod_p1_d[i] = accept ? d_ext * w_ext : prod_p1_q[i];
      end
      vld_p1_d   = accept;
      first_p1_d = accept ? (beat_q == '0) : first_p1_q;
      last_p1_d  = accept ? (beat_q == BEAT_LAST) : last_p1_q;
      nidx_p1_d  = accept ? nidx_q : nidx_p1_q;
      bias_p1_d  = accept ? bias_in : bias_p1_q;
   end

   // Stage 2: lane sum
   always_comb begin
      sum_p2_d = '0;
      for (int i = 0; i < LANES; i++)
         sum_p2_d = sum_p2_d + {{(ACC_W-PW){prod_p1_q[i][PW-1]}}, prod_p1_q[i]};
      vld_p2_d   = vld_p1_q;
      first_p2_d = first_p1_q;
      last_p2_d  = last_p1_q;
      nidx_p2_d  = nidx_p1_q;
      bias_p2_d  = bias_p1_q;
   end

   // Stage 3: accumulate, bias folded in on the first beat
   always_comb begin
      acc_p3_d = acc_p3_q;
      if (vld_p2_q) begin
         if (first_p2_q)
            acc_p3_d = sum_p2_q + ({{(ACC_W-DATA_W){bias_p2_q[DATA_W-1]}}, bias_p2_q} << FRAC_W);
         else
            acc_p3_d = acc_p3_q + sum_p2_q;
      end
      vld_p3_d  = vld_p2_q;
      last_p3_d = last_p2_q;
      nidx_p3_d = nidx_p2_q;
   end

   // Result write-back: shift, saturate, optional ReLU
   always_comb begin
      slot_d      = slot_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      sat_res     = shift_sat(acc_p3_q);
      if (start_acc) begin
         for (int k = 0; k < NEURONS; k++) slot_d[k] = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (vld_p3_q && last_p3_q) begin
            slot_d[nidx_p3_q] = relu_clamp(sat_res[DATA_W-1:0], relu_q);
            if (sat_res[DATA_W]) ovf_d = 1'b1;
         end
         if (state_q == DRAIN && state_d == DONE) out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         nidx_q      <= '0;
         relu_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         for (int i = 0; i < LANES; i++) prod_p1_q[i] <= '0;
         vld_p1_q    <= 1'b0;
         first_p1_q  <= 1'b0;
         last_p1_q   <= 1'b0;
         nidx_p1_q   <= '0;
         bias_p1_q   <= '0;
         sum_p2_q    <= '0;
         vld_p2_q    <= 1'b0;
         first_p2_q  <= 1'b0;
         last_p2_q   <= 1'b0;
         nidx_p2_q   <= '0;
         bias_p2_q   <= '0;
         acc_p3_q    <= '0;
         vld_p3_q    <= 1'b0;
         last_p3_q   <= 1'b0;
         nidx_p3_q   <= '0;
         for (int k = 0; k < NEURONS; k++) slot_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         nidx_q      <= nidx_d;
         relu_q      <= relu_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         for (int i = 0; i < LANES; i++) prod_p1_q[i] <= prod_p1_d[i];
         vld_p1_q    <= vld_p1_d;
         first_p1_q  <= first_p1_d;
         last_p1_q   <= last_p1_d;
         nidx_p1_q   <= nidx_p1_d;
         bias_p1_q   <= bias_p1_d;
         sum_p2_q    <= sum_p2_d;
         vld_p2_q    <= vld_p2_d;
         first_p2_q  <= first_p2_d;
         last_p2_q   <= last_p2_d;
         nidx_p2_q   <= nidx_p2_d;
         bias_p2_q   <= bias_p2_d;
         acc_p3_q    <= acc_p3_d;
         vld_p3_q    <= vld_p3_d;
         last_p3_q   <= last_p3_d;
         nidx_p3_q   <= nidx_p3_d;
         for (int k = 0; k < NEURONS; k++) slot_q[k] <= slot_d[k];
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

   for (genvar k = 0; k < NEURONS; k++) begin : g_out
      assign data_out[k*DATA_W +: DATA_W] = slot_q[k];
   end

endmodule

// File: tb/tb_dense_mac_engine.sv
// Directed bench for dense_mac_engine: unity, bias with back-pressure, negative/ReLU,
// saturation both ways, reset mid-run and start-while-busy.
module tb_dense_mac_engine;

   localparam int DATA_W  = 16;
   localparam int LANES   = 6;
   localparam int BEATS   = 4;
   localparam int NEURONS = 24;
   localparam int NB      = NEURONS*BEATS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic relu_en = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready, busy, done, out_valid, ovf;
   logic [LANES*DATA_W-1:0]   data_in = '0;
   logic [LANES*DATA_W-1:0]   weight_in = '0;
   logic [DATA_W-1:0]         bias_in = '0;
   logic [NEURONS*DATA_W-1:0] data_out;

   int errors = 0;
   int checks = 0;
   int acc_n, done_n, lat;

   always #5 clk = ~clk;

   dense_mac_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .relu_en   (relu_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .weight_in (weight_in),
      .bias_in   (bias_in),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .ovf       (ovf),
      .data_out  (data_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_slots(input string tag, input logic [DATA_W-1:0] exp);
      for (int k = 0; k < NEURONS; k++)
         chk($sformatf("%s slot%0d", tag, k), 32'(data_out[k*DATA_W +: DATA_W]), 32'(exp));
   endtask

   // One complete run; restart_at > 0 raises start again at that cycle of the run.
   task automatic run(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] w,
                      input logic [DATA_W-1:0] b, input logic relu,
                      input logic toggle, input int restart_at);
      @(posedge clk); #1;
      start     = 1'b1;
      relu_en   = relu;
      data_in   = {LANES{d}};
      weight_in = {LANES{w}};
      bias_in   = b;
      @(posedge clk); #1;
      start   = 1'b0;
      relu_en = ~relu;
      chk("start clears out_valid", 32'(out_valid), 32'd0);
      chk("start clears ovf", 32'(ovf), 32'd0);
      chk("start clears data_out", 32'(data_out == '0), 32'd1);
      acc_n  = 0;
      done_n = 0;
      lat    = -1;
      for (int c = 1; c <= 600; c++) begin
         in_valid = toggle ? c[0] : 1'b1;
         start    = (c == restart_at);
         if (in_valid && in_ready) acc_n++;
         @(posedge clk); #1;
         if (done) begin
            done_n++;
            if (lat < 0) lat = c;
         end else if (lat >= 0) begin
            break;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic post(input string tag, input logic [DATA_W-1:0] exp,
                       input logic exp_ovf, input int exp_lat);
      chk({tag, " beats accepted"}, 32'(acc_n), 32'(NB));
      chk({tag, " done width"}, 32'(done_n), 32'd1);
      chk({tag, " done latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " busy after"}, 32'(busy), 32'd0);
      chk_slots(tag, exp);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset ovf", 32'(ovf), 32'd0);
      chk("reset data_out", 32'(data_out == '0), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle busy", 32'(busy), 32'd0);

      run(16'h0020, 16'h0020, 16'h0000, 1'b0, 1'b0, 0);
      post("unity", 16'h0300, 1'b0, NB + 3);
      repeat (5) @(posedge clk);
      #1;
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold slot0", 32'(data_out[DATA_W-1:0]), 32'h0300);

      // Beats land on every other cycle: last beat at 2*NB-1, result 3 edges later.
      run(16'h0020, 16'h0020, 16'h0020, 1'b0, 1'b1, 0);
      post("bias_bp", 16'h0320, 1'b0, 2*NB + 2);

      run(16'h0020, 16'hFFE0, 16'h0000, 1'b0, 1'b0, 0);
      post("negative", 16'hFD00, 1'b0, NB + 3);

      run(16'h0020, 16'hFFE0, 16'h0000, 1'b1, 1'b0, 0);
      post("relu", 16'h0000, 1'b0, NB + 3);

      run(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 0);
      post("sat_pos", 16'h7FFF, 1'b1, NB + 3);

      run(16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 0);
      post("sat_neg", 16'h8000, 1'b1, NB + 3);

      run(16'h0020, 16'h0020, 16'h0000, 1'b0, 1'b0, 10);
      post("start_busy", 16'h0300, 1'b0, NB + 3);

      @(posedge clk); #1;
      start     = 1'b1;
      relu_en   = 1'b0;
      data_in   = {LANES{16'h0020}};
      weight_in = {LANES{16'h0020}};
      bias_in   = 16'h0000;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      acc_n    = 0;
      for (int c = 0; c < 200 && acc_n < 50; c++) begin
         if (in_ready) acc_n++;
         @(posedge clk); #1;
      end
      chk("midrun beats before reset", 32'(acc_n), 32'd50);
      chk("midrun busy before reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrun reset busy", 32'(busy), 32'd0);
      chk("midrun reset in_ready", 32'(in_ready), 32'd0);
      chk("midrun reset done", 32'(done), 32'd0);
      chk("midrun reset out_valid", 32'(out_valid), 32'd0);
      chk("midrun reset ovf", 32'(ovf), 32'd0);
      chk("midrun reset data_out", 32'(data_out == '0), 32'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after reset in_ready", 32'(in_ready), 32'd0);

      run(16'h0020, 16'h0020, 16'h0000, 1'b0, 1'b0, 0);
      post("after_reset", 16'h0300, 1'b0, NB + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
